mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store initiator that sits between the multicycle datapath and the word-wide data memory.
- Accepts one byte, halfword or word load/store request at a time from the control unit.
- Converts the byte address to the memory's word index and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data, or an error flag for misaligned or out-of-range addresses.

Parameters:
WORD_ADDR_BITS, 8, width of the memory word index; the memory holds 2**WORD_ADDR_BITS words of 32 bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid; request was rejected
resp_rdata  output  32  extended load data; 0 for stores and errors
mem_address  output  32  word index {zeros, addr[WORD_ADDR_BITS+1:2]}
mem_write  output  1  write strobe to memory
mem_wdata  output  32  merged write word
mem_rdata  input  32  combinational read data for mem_address

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_address=0, mem_wdata=0; all latched request fields cleared. Reset while in any state aborts the access, and mem_write drops immediately.
- Byte lanes are little-endian: offset addr[1:0]=0 maps to bits [7:0]; a halfword at offset 2 maps to bits [31:16].
- Request handshake: a request is accepted when req_valid && req_ready at a rising edge. The unit latches addr, size, write, signed and wdata. Inputs are ignored outside IDLE.
- Error check at accept:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:WORD_ADDR_BITS+2] nonzero.
  - Illegal size: req_size = 11.
  - Any error goes to RESP with resp_err=1 and no memory access.
- States:
  - IDLE: req_ready=1, mem_write=0.
    - Accept with error -> RESP.
    - Load -> RD.
    - Word store -> WR.
    - Sub-word store -> RD.
  - RD: drive mem_address; capture mem_rdata into the word register at the edge.
    - Load -> RESP.
    - Store -> WR.
  - WR: mem_write=1 for exactly this one cycle. mem_wdata is either req_wdata (word) or the captured word with the addressed lane replaced by the low byte/half of req_wdata. Next state is RESP.
  - RESP: resp_valid=1 for one cycle. resp_rdata is the addressed lane extended per req_signed (word passes through); it is 0 for stores and errors. Next state is IDLE.
- Registered outputs: resp_valid, resp_err and resp_rdata are registered, so they are valid during RESP. mem_address and mem_wdata are held stable from RD/WR entry until IDLE.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back requests: the earliest next accept is the cycle after RESP. There is no overlap or pipelining.
- Unsigned byte/half loads clear the upper bits regardless of the memory contents.

Test Plan:
- Memory preloaded mem[i]=i; lw addr 0x10 -> resp_valid 2 cycles after accept, resp_rdata=0x00000004, resp_err=0, mem_write never high.
- sb wdata 0xAB85 to addr 0x0D (mem[3]=0x3) -> one RD cycle, then one WR cycle with mem_address=3 and mem_wdata=0x00008503. resp_valid follows 3 cycles after accept, resp_rdata=0.
- After the previous step: lb signed addr 0x0D -> resp_rdata=0xFFFFFF85; lbu addr 0x0D -> 0x00000085; lhu addr 0x0E -> 0x00000000.
- sw 0xDEADBEEF to addr 0x3FC -> mem[255]=0xDEADBEEF. lh signed addr 0x3FE -> 0xFFFFDEAD.
- Error cases, each giving resp_err=1 one cycle after accept, resp_rdata=0 and no mem_write pulse:
  - lw addr 0x02 (misaligned);
  - lh addr 0x05 (misaligned);
  - sw addr 0x400 (out of range);
  - req_size=11.
- Assert rst low during the WR cycle of a sub-word store -> mem_write and resp_valid drop immediately, req_ready=1 after release, and the next lw completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator between the multicycle datapath and a word-wide data memory.
// Handles byte/half/word accesses, read-modify-write for sub-word stores, and load extension.
module mem_access_unit #(
    parameter int WORD_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the request inputs are ignored elsewhere.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic        lat_signed;
    logic [15:0] lat_wdata;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        bad_size;
    logic        req_err;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic [15:0] data);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            r[{off, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = data;
        end
        return r;
    endfunction

    assign accept       = req_valid && (state == IDLE);
    assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign out_of_range = |req_addr[31:WORD_ADDR_BITS+2];
    assign bad_size     = (req_size == 2'b11);
    assign req_err      = misaligned || out_of_range || bad_size;
    assign fsm_state    = state;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = lat_write ? WR : RESP;
            WR: begin
                mem_write = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_off     <= 2'b00;
            lat_size    <= 2'b00;
            lat_write   <= 1'b0;
            lat_signed  <= 1'b0;
            lat_wdata   <= 16'h0;
            mem_address <= 32'h0;
            mem_wdata   <= 32'h0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_off    <= req_addr[1:0];
                lat_size   <= req_size;
                lat_write  <= req_write;
                lat_signed <= req_signed;
                lat_wdata  <= req_wdata[15:0];
                // Rejected requests never touch the memory-side registers.
                if (!req_err) begin
                    mem_address <= {{(32-WORD_ADDR_BITS){1'b0}}, req_addr[WORD_ADDR_BITS+1:2]};
                    if (req_write && (req_size == 2'b10)) begin
                        mem_wdata <= req_wdata;
                    end
                end
            end
            if ((state == RD) && lat_write) begin
                mem_wdata <= merge(mem_rdata, lat_off, lat_size, lat_wdata);
            end
            resp_valid <= (state_nxt == RESP);
            resp_err   <= accept && req_err;
            resp_rdata <= ((state == RD) && !lat_write) ?
                          extract(mem_rdata, lat_off, lat_size, lat_signed) : 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: models a 256-word memory and checks latency,
// responses, write strobes and asynchronous reset abort against hand-computed values.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  fsm_state;

    logic [31:0] mem [0:255];
    int          wr_cnt;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    int          errors;
    int          checks;

    mem_access_unit #(.WORD_ADDR_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address[7:0]];

    initial begin
        wr_cnt       = 0;
        last_wr_addr = 32'h0;
        last_wr_data = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = i;
        forever begin
            @(posedge clk);
            if (rst && mem_write) begin
                mem[mem_address[7:0]] = mem_wdata;
                last_wr_addr = mem_address;
                last_wr_data = mem_wdata;
                wr_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: starts at a negedge in IDLE, returns at the negedge after RESP.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_wr);
        int n;
        int wr_before;
        wr_before  = wr_cnt;
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, exp_lat);
        check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        @(negedge clk);
        check({tag, ".rv_pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".writes"}, wr_cnt - wr_before, exp_wr);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        #1;
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.resp_err", {31'h0, resp_err}, 32'h0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.mem_write", {31'h0, mem_write}, 32'h0);
        check("rst.mem_address", mem_address, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        check("rst.state", {30'h0, fsm_state}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h4, 0);

        run_req("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'hAB85, 3, 1'b0, 32'h0, 1);
        check("sb_0d.waddr", last_wr_addr, 32'h3);
        check("sb_0d.wdata", last_wr_data, 32'h0000_8503);

        run_req("lb_0d", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 2, 1'b0, 32'hFFFF_FF85, 0);
        run_req("lbu_0d", 1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 2, 1'b0, 32'h0000_0085, 0);
        run_req("lhu_0e", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 2, 1'b0, 32'h0, 0);
        run_req("lh_0c", 1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 2, 1'b0, 32'hFFFF_8503, 0);

        run_req("sw_3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1);
        check("sw_3fc.waddr", last_wr_addr, 32'hFF);
        check("sw_3fc.mem", mem[255], 32'hDEAD_BEEF);
        run_req("lh_3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 2, 1'b0, 32'hFFFF_DEAD, 0);

        run_req("sh_3fe", 1'b1, 2'b01, 1'b0, 32'h3FE, 32'h5555_1234, 3, 1'b0, 32'h0, 1);
        check("sh_3fe.wdata", last_wr_data, 32'h1234_BEEF);
        run_req("lw_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, 32'h1234_BEEF, 0);
        run_req("lbu_3ff", 1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 2, 1'b0, 32'h0000_0012, 0);
        run_req("lb_3fc", 1'b0, 2'b00, 1'b1, 32'h3FC, 32'h0, 2, 1'b0, 32'hFFFF_FFEF, 0);

        run_req("err_lw_02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1, 1'b1, 32'h0, 0);
        run_req("err_lh_05", 1'b0, 2'b01, 1'b1, 32'h05, 32'h0, 1, 1'b1, 32'h0, 0);
        run_req("err_sw_400", 1'b1, 2'b10, 1'b0, 32'h400, 32'h1111_2222, 1, 1'b1, 32'h0, 0);
        run_req("err_size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 0);
        check("err.mem255", mem[255], 32'h1234_BEEF);

        // Sub-word store aborted by reset during its WR cycle.
        begin
            int wr_before;
            wr_before  = wr_cnt;
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_size   = 2'b00;
            req_signed = 1'b0;
            req_addr   = 32'h20;
            req_wdata  = 32'h77;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            check("abort.rd_no_write", {31'h0, mem_write}, 32'h0);
            @(negedge clk);
            check("abort.wr_cycle", {31'h0, mem_write}, 32'h1);
            #1 rst = 1'b0;
            #1;
            check("abort.mem_write", {31'h0, mem_write}, 32'h0);
            check("abort.resp_valid", {31'h0, resp_valid}, 32'h0);
            check("abort.ready_in_rst", {31'h0, req_ready}, 32'h1);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("abort.ready", {31'h0, req_ready}, 32'h1);
            check("abort.resp_valid2", {31'h0, resp_valid}, 32'h0);
            check("abort.writes", wr_cnt - wr_before, 0);
            check("abort.mem8", mem[8], 32'h8);
            @(negedge clk);
        end
        run_req("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
